// File: rtl/imem_loader.sv
// imem_loader: instruction-memory loader.
// Accepts a byte stream over a valid/ready handshake, assembles big-endian
// 32-bit words (first byte lands in bits [31:24]) and writes each word to
// consecutive word-aligned addresses through the memory cs/wr port. The CPU
// is held off (cpu_hold) while a load is in progress; done marks a complete
// program image.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   start, word_count   load request pulse and number of words (clamped to 1024)
//   byte_valid, byte_in source byte stream
//   byte_ready          loader accepts a byte this cycle
//   im_cs, im_wr        memory chip select / write strobe (WRITE state only)
//   im_addr, im_din     memory byte address / write data
//   busy, cpu_hold      load in progress (COLLECT or WRITE)
//   done                load finished, held until the next start
module imem_loader #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [10:0]       word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              im_cs,
    output logic              im_wr,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic [1:0]        byte_idx;
    logic [10:0]       count;
    logic [10:0]       words_done;

    // Largest image the 4 KB memory can hold is 1024 words.
    function automatic logic [10:0] clamp_count(input logic [10:0] wc);
        return (wc > 11'd1024) ? 11'd1024 : wc;
    endfunction

    // Single FSM; byte_ready/im_wr/busy/done are registered and updated on
    // every state transition so they always match the state being entered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            addr       <= BASE_ADDR;
            word       <= '0;
            byte_idx   <= '0;
            count      <= '0;
            words_done <= '0;
            byte_ready <= 1'b0;
            im_wr      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count      <= clamp_count(word_count);
                        addr       <= BASE_ADDR;
                        byte_idx   <= '0;
                        words_done <= '0;
                        if (word_count == 11'd0) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                        end
                        im_wr <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        word     <= {word[23:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            im_wr      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    addr       <= addr + ADDR_W'(4);
                    words_done <= words_done + 11'd1;
                    im_wr      <= 1'b0;
                    if (words_done + 11'd1 == count) begin
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        state      <= COLLECT;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    im_wr      <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign im_cs    = im_wr;
    assign cpu_hold = busy;
    assign im_addr  = addr;
    assign im_din   = word;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [10:0] word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_ready, im_cs, im_wr, busy, cpu_hold, done;
    logic [11:0] im_addr;
    logic [31:0] im_din;

    // second instance with a non-zero base for the wrap/clamp case
    logic        start2 = 1'b0;
    logic [10:0] word_count2 = '0;
    logic        byte_valid2 = 1'b0;
    logic [7:0]  byte_in2 = '0;
    logic        byte_ready2, im_cs2, im_wr2, busy2, cpu_hold2, done2;
    logic [11:0] im_addr2;
    logic [31:0] im_din2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] wq_addr[$];
    logic [31:0] wq_din[$];

    always #5 CLK = ~CLK;

    imem_loader #(.ADDR_W(12), .BASE_ADDR(12'h000)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .im_cs(im_cs), .im_wr(im_wr), .im_addr(im_addr), .im_din(im_din),
        .busy(busy), .cpu_hold(cpu_hold), .done(done)
    );

    imem_loader #(.ADDR_W(12), .BASE_ADDR(12'hFF8)) dut2 (
        .CLK(CLK), .RESET(RESET), .start(start2), .word_count(word_count2),
        .byte_valid(byte_valid2), .byte_in(byte_in2), .byte_ready(byte_ready2),
        .im_cs(im_cs2), .im_wr(im_wr2), .im_addr(im_addr2), .im_din(im_din2),
        .busy(busy2), .cpu_hold(cpu_hold2), .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Write monitor for the main instance
    always @(negedge CLK) begin
        if (im_wr === 1'b1) begin
            wq_addr.push_back(im_addr);
            wq_din.push_back(im_din);
            chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            chk("cs_with_wr", {31'd0, im_cs}, 32'd1);
        end
    end

    task automatic clear_q();
        wq_addr.delete();
        wq_din.delete();
    endtask

    task automatic pulse_start(input logic [10:0] wc);
        start = 1'b1;
        word_count = wc;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        logic acc;
        byte_valid = 1'b0;
        repeat (gap) @(negedge CLK);
        byte_valid = 1'b1;
        byte_in = b;
        t = 0;
        forever begin
            acc = byte_ready;
            @(negedge CLK);
            if (acc) break;
            t++;
            if (t > 40) begin
                fail_now("byte_accept");
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int t;
        t = 0;
        while (done !== 1'b1 && t < bound) begin
            @(negedge CLK);
            t++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_im_cs"}, {31'd0, im_cs}, 32'd0);
        chk({tag, "_im_wr"}, {31'd0, im_wr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_im_addr"}, {20'd0, im_addr}, 32'h000);
    endtask

    typedef struct {
        logic        st;
        logic [10:0] wc;
        logic        bv;
        logic [7:0]  bi;
        logic        br;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] din;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int nw;
        logic [11:0] exp_a;
        int gaps[12];

        // Row: drive {st,wc,bv,bi} after checking {br,wr,addr,din(if wr),busy,done}
        tbl[0] = '{1'b1, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 11'd1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 11'd1, 1'b1, 8'h8C, 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 11'd1, 1'b1, 8'h01, 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 11'd1, 1'b1, 8'h00, 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 11'd1, 1'b1, 8'h04, 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 11'd1, 1'b1, 8'h55, 1'b0, 1'b1, 12'h000, 32'h8C010004, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 11'd1, 1'b1, 8'h55, 1'b0, 1'b0, 12'h004, 32'h0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 11'd1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h004, 32'h0, 1'b0, 1'b1};
        gaps = '{0, 2, 1, 0, 3, 0, 0, 1, 2, 0, 0, 1};

        // Reset behaviour
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check_idle_outputs("reset");
        chk("reset_im_din", im_din, 32'h0);
        chk("reset_addr_base2", {20'd0, im_addr2}, 32'hFF8);
        RESET = 1'b0;
        clear_q();

        // Table: zero-count start, restart from DONE, single word 8C010004
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl%0d_byte_ready", i), {31'd0, byte_ready}, {31'd0, tbl[i].br});
            chk($sformatf("tbl%0d_im_wr", i), {31'd0, im_wr}, {31'd0, tbl[i].wr});
            chk($sformatf("tbl%0d_im_addr", i), {20'd0, im_addr}, {20'd0, tbl[i].addr});
            chk($sformatf("tbl%0d_busy", i), {30'd0, busy, cpu_hold}, {30'd0, tbl[i].bsy, tbl[i].bsy});
            chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
            if (tbl[i].wr)
                chk($sformatf("tbl%0d_im_din", i), im_din, tbl[i].din);
            start = tbl[i].st;
            word_count = tbl[i].wc;
            byte_valid = tbl[i].bv;
            byte_in = tbl[i].bi;
            @(negedge CLK);
        end
        chk("tbl_write_count", wq_addr.size(), 1);

        // Three words with byte_valid gaps
        clear_q();
        pulse_start(11'd3);
        for (int i = 0; i < 12; i++) send_byte(8'(i), gaps[i]);
        wait_done(20);
        chk("three_write_count", wq_addr.size(), 3);
        if (wq_addr.size() == 3) begin
            chk("three_a0", {20'd0, wq_addr[0]}, 32'h000);
            chk("three_d0", wq_din[0], 32'h00010203);
            chk("three_a1", {20'd0, wq_addr[1]}, 32'h004);
            chk("three_d1", wq_din[1], 32'h04050607);
            chk("three_a2", {20'd0, wq_addr[2]}, 32'h008);
            chk("three_d2", wq_din[2], 32'h08090A0B);
        end

        // Ignored start during COLLECT, then no consumption in DONE
        clear_q();
        pulse_start(11'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        start = 1'b1;
        word_count = 11'd5;
        @(negedge CLK);
        start = 1'b0;
        chk("ign_start_busy", {31'd0, busy}, 32'd1);
        chk("ign_start_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 0);
        wait_done(10);
        chk("ign_write_count", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            chk("ign_d0", wq_din[0], 32'h11223344);
            chk("ign_a1", {20'd0, wq_addr[1]}, 32'h004);
            chk("ign_d1", wq_din[1], 32'h50515253);
        end
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            chk("done_ready_low", {31'd0, byte_ready}, 32'd0);
            chk("done_held", {31'd0, done}, 32'd1);
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        chk("done_no_writes", wq_addr.size(), 2);

        // Reset mid-load
        clear_q();
        pulse_start(11'd3);
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 0);
        send_byte(8'hD0, 0);
        send_byte(8'hD1, 0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_idle_outputs("midrst");
        byte_valid = 1'b1;
        byte_in = 8'h77;
        repeat (6) @(negedge CLK);
        byte_valid = 1'b0;
        chk("midrst_write_count", wq_addr.size(), 1);
        pulse_start(11'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        wait_done(10);
        chk("midrst_total_writes", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            chk("midrst_d0", wq_din[0], 32'hC0C1C2C3);
            chk("deadbeef_addr", {20'd0, wq_addr[1]}, 32'h000);
            chk("deadbeef_din", wq_din[1], 32'hDEADBEEF);
        end

        // Wrap and clamp on the FF8-based instance
        start2 = 1'b1;
        word_count2 = 11'd2047;
        @(negedge CLK);
        start2 = 1'b0;
        byte_valid2 = 1'b1;
        byte_in2 = 8'hA5;
        nw = 0;
        for (int t = 0; t < 6000 && nw < 1024; t++) begin
            if (im_wr2 === 1'b1) begin
                exp_a = 12'hFF8 + 12'(4 * nw);
                chk($sformatf("wrap_addr%0d", nw), {20'd0, im_addr2}, {20'd0, exp_a});
                if (nw == 0) chk("wrap_din0", im_din2, 32'hA5A5A5A5);
                nw++;
            end
            @(negedge CLK);
        end
        chk("wrap_write_count", nw, 1024);
        chk("wrap_done", {31'd0, done2}, 32'd1);
        chk("wrap_busy", {31'd0, busy2}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (im_wr2 === 1'b1) nw++;
            @(negedge CLK);
        end
        byte_valid2 = 1'b0;
        chk("wrap_no_extra_write", nw, 1024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write-side counterpart of the CPU's instruction fetch path. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into instruction memory at consecutive word-aligned addresses through the memory's `cs`/`wr` port. The CPU is held off while loading; `done` flags a completed program image so the controller can release reset/fetch.

## Interface
- `ADDR_W`, 12: instruction memory byte-address width (4 KB image).
- `BASE_ADDR`, 12'h000: byte address of the first word written; must be a multiple of 4.
- `CLK`  in  1: system clock; all state changes on rising edge.
- `RESET`  in  1: reset; synchronous and active-high.
- `start`  in  1: one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `word_count`  in  11: number of words to load, sampled on accepted `start`; 0 = no writes; >1024 clamped to 1024.
- `byte_valid`  in  1: source has a byte on `byte_in`.
- `byte_in`  in  8: data byte; first byte of each word is bits [31:24].
- `byte_ready`  out  1: loader accepts a byte this cycle; transfer occurs when `byte_valid && byte_ready`.
- `im_cs`  out  1: instruction memory chip select.
- `im_wr`  out  1: instruction memory write strobe (asserted together with `im_cs`).
- `im_addr`  out  ADDR_W: byte address for the write.
- `im_din`  out  32: word to write.
- `busy`  out  1: load in progress (COLLECT or WRITE).
- `cpu_hold`  out  1: equals `busy`; stalls PC/IR loading.
- `done`  out  1: load finished; held high in DONE.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `byte_ready`=0, no writes. An accepted `start` latches `word_count` (clamped), sets the address to BASE_ADDR, and clears the byte index (0..3) and the word counter. The next state is COLLECT, or DONE directly when `word_count`=0.
- COLLECT: `byte_ready`=1. Each handshake shifts the byte into the word register (`word <= {word[23:0], byte_in}`) and increments the byte index. On the 4th byte (index 3) the next state is WRITE and the index wraps to 0. Cycles with `byte_valid`=0 are stalls and leave state unchanged.
- WRITE: lasts exactly one cycle, with `byte_ready`=0.
  - `im_cs`=`im_wr`=1, `im_addr`=current address, `im_din`=assembled word.
  - On exit, address += 4 (modulo 2^ADDR_W) and word counter += 1.
  - If the word counter now equals the latched count, the next state is DONE; otherwise COLLECT.
- DONE: `done`=1 and `byte_ready`=0; bytes presented are not consumed. An accepted `start` begins a new load exactly as from IDLE and clears `done`.
- `start` in COLLECT/WRITE is ignored. `word_count` changes after the start cycle have no effect.
- Address wrap: a 1024-word load from BASE_ADDR≠0 wraps past 12'hFFC to 12'h000; this is permitted and not flagged.
- `im_cs`/`im_wr` are never asserted outside WRITE. The loader never drives a read.

## Timing
- Reset values (every output): `byte_ready`=0, `im_cs`=0, `im_wr`=0, `im_addr`=BASE_ADDR, `im_din`=0, `busy`=0, `cpu_hold`=0, `done`=0. The state returns to IDLE.
- RESET mid-load: the partial word is discarded and words already written stay in memory. No write strobe occurs in the reset cycle or after it until a new `start`.
- `start` accepted at edge k: `byte_ready`=1 and `busy`=1 in cycle k+1.
- 4th byte accepted at edge n: the write strobe is high during cycle n+1 and is sampled by memory at edge n+2. `byte_ready` returns high in cycle n+2.
- Best-case throughput: 5 cycles per word with `byte_valid` held high.
- Last write cycle m: `done`=1 and `busy`=0 from cycle m+1.
- All outputs are registered or decoded from registered state only; no combinational path from `byte_valid`/`byte_in` to any output.

## Test plan
- Reset behaviour: assert RESET 2 cycles → all outputs at reset values and `im_addr`=12'h000. `start` with `word_count`=0 → `done`=1 next cycle, no `im_wr` pulse.
- Single word, continuous stream: `word_count`=1; bytes 8C, 01, 00, 04 on consecutive cycles → one `im_wr` pulse with `im_addr`=000 and `im_din`=32'h8C010004, then `done`=1. Total from start to `done` is 6 cycles.
- Three words with random `byte_valid` gaps: stream 00..0B → writes 00010203@000, 04050607@004, 08090A0B@008. Exactly 3 strobes; `byte_ready` is low in each WRITE cycle.
- Back-pressure and ignored start: pulse `start` during COLLECT → no restart and the count is unchanged. In DONE, held `byte_valid`=1 is never accepted (`byte_ready`=0).
- Reset mid-load: after 2 bytes of word 2, assert RESET → no further `im_wr`. A new `start` with `word_count`=1 and bytes DE, AD, BE, EF writes DEADBEEF@000.
- Wrap and clamp: BASE_ADDR=12'hFF8, `word_count`=2047 → count clamped to 1024. Addresses run FF8, FFC, 000, 004, …, FF4 (the 1024th write); `done` follows the 1024th write.
